// File: rtl/result_pkg.sv
// Shared constants for the result collector: default geometry and counter saturation limits.
package result_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned DROP_MAX      = 255;
  localparam int unsigned SAMPLES_MAX   = 65535;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered head output; occupancy drives full/empty, pointers wrap freely.
module result_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/result_collector.sv
// Buffers upstream samples without backpressure, dropping on overflow, and keeps running
// statistics (count, sum, min, max) over accepted samples.
module result_collector
  import result_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  localparam int unsigned CntW = $clog2(DEPTH) + 1,
  localparam int unsigned SumW = WIDTH + 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CntW-1:0]  o_count,
  output logic             o_overflow,
  output logic [7:0]       o_drops,
  output logic [15:0]      o_samples,
  output logic [SumW-1:0]  o_sum,
  output logic [WIDTH-1:0] o_min,
  output logic [WIDTH-1:0] o_max
);

  logic full, pop, push, drop;

  logic             overflow_q, overflow_d;
  logic [7:0]       drops_q, drops_d;
  logic [15:0]      samples_q, samples_d;
  logic [SumW-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  // A pop frees a slot on the same edge, so a full FIFO still accepts when drained.
  assign pop  = o_valid & o_ready;
  assign push = i_valid & (~full | pop);
  assign drop = i_valid & full & ~pop;

  result_fifo #(
    .Depth (DEPTH),
    .Width (WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (i_value),
    .rdata_o (o_data),
    .valid_o (o_valid),
    .full_o  (full),
    .count_o (o_count)
  );

  always_comb begin
    overflow_d = overflow_q;
    drops_d    = drops_q;
    samples_d  = samples_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    // Clear wins over a coincident push or drop; the sample itself still enters the FIFO.
    if (i_clear) begin
      overflow_d = 1'b0;
      drops_d    = '0;
      samples_d  = '0;
      sum_d      = '0;
      min_d      = '1;
      max_d      = '0;
    end else begin
      if (push) begin
        if (samples_q != 16'(SAMPLES_MAX)) begin
          samples_d = samples_q + 16'd1;
        end
        sum_d = sum_q + SumW'(i_value);
        if (i_value < min_q) begin
          min_d = i_value;
        end
        if (i_value > max_q) begin
          max_d = i_value;
        end
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drops_q != 8'(DROP_MAX)) begin
          drops_d = drops_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drops_q    <= '0;
      samples_q  <= '0;
      sum_q      <= '0;
      min_q      <= '1;
      max_q      <= '0;
    end else begin
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
      samples_q  <= samples_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
    end
  end

  assign o_overflow = overflow_q;
  assign o_drops    = drops_q;
  assign o_samples  = samples_q;
  assign o_sum      = sum_q;
  assign o_min      = min_q;
  assign o_max      = max_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: FIFO ordering, overflow/drop, statistics, clear and reset.
module tb_result_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CntW  = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_value = '0;
  logic             i_clear = 1'b0;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic [CntW-1:0]  o_count;
  logic             o_overflow;
  logic [7:0]       o_drops;
  logic [15:0]      o_samples;
  logic [WIDTH+7:0] o_sum;
  logic [WIDTH-1:0] o_min;
  logic [WIDTH-1:0] o_max;

  int checks = 0;
  int errors = 0;

  logic [31:0] drain_exp [8] = '{32'd1, 32'd20, 32'd21, 32'd22, 32'd23, 32'd24, 32'd30, 32'd5};

  result_collector #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_value    (i_value),
    .i_clear    (i_clear),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_drops    (o_drops),
    .o_samples  (o_samples),
    .o_sum      (o_sum),
    .o_min      (o_min),
    .o_max      (o_max)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    i_valid = 1'b1;
    i_value = v;
    step();
    i_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 64'(o_count), 64'd0);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_data"}, 64'(o_data), 64'd0);
    check({tag, "_ovf"}, 64'(o_overflow), 64'd0);
    check({tag, "_drops"}, 64'(o_drops), 64'd0);
    check({tag, "_samples"}, 64'(o_samples), 64'd0);
    check({tag, "_sum"}, 64'(o_sum), 64'd0);
    check({tag, "_min"}, 64'(o_min), 64'hFFFF_FFFF);
    check({tag, "_max"}, 64'(o_max), 64'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check_reset_state("rst");
    step();
    reset = 1'b0;
    step();

    // First push is visible right after its edge
    push(32'd3);
    check("lat_valid", 64'(o_valid), 64'd1);
    check("lat_data", 64'(o_data), 64'd3);
    push(32'd7);
    push(32'd1);
    check("p3_count", 64'(o_count), 64'd3);
    check("p3_data", 64'(o_data), 64'd3);
    check("p3_samples", 64'(o_samples), 64'd3);
    check("p3_sum", 64'(o_sum), 64'd11);
    check("p3_min", 64'(o_min), 64'd1);
    check("p3_max", 64'(o_max), 64'd7);

    // Ten pushes into a depth-8 FIFO: last two dropped
    for (int v = 20; v < 27; v++) push(32'(v));
    check("ovf_count", 64'(o_count), 64'd8);
    check("ovf_drops", 64'(o_drops), 64'd2);
    check("ovf_flag", 64'(o_overflow), 64'd1);
    check("ovf_samples", 64'(o_samples), 64'd8);
    check("ovf_sum", 64'(o_sum), 64'd121);
    check("ovf_max", 64'(o_max), 64'd24);

    // Full with simultaneous push and pop
    o_ready = 1'b1;
    push(32'd30);
    o_ready = 1'b0;
    check("fpp_count", 64'(o_count), 64'd8);
    check("fpp_drops", 64'(o_drops), 64'd2);
    check("fpp_data", 64'(o_data), 64'd7);
    check("fpp_samples", 64'(o_samples), 64'd9);
    check("fpp_max", 64'(o_max), 64'd30);

    // Pop one, then clear alongside a push
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    check("pop_count", 64'(o_count), 64'd7);
    check("pop_data", 64'(o_data), 64'd1);
    i_clear = 1'b1;
    push(32'd5);
    i_clear = 1'b0;
    check("clr_count", 64'(o_count), 64'd8);
    check("clr_data", 64'(o_data), 64'd1);
    check("clr_samples", 64'(o_samples), 64'd0);
    check("clr_sum", 64'(o_sum), 64'd0);
    check("clr_min", 64'(o_min), 64'hFFFF_FFFF);
    check("clr_max", 64'(o_max), 64'd0);
    check("clr_ovf", 64'(o_overflow), 64'd0);

    // Drop, then clear alongside a drop
    push(32'd40);
    check("drop_drops", 64'(o_drops), 64'd1);
    check("drop_ovf", 64'(o_overflow), 64'd1);
    i_clear = 1'b1;
    push(32'd41);
    i_clear = 1'b0;
    check("clrdrop_drops", 64'(o_drops), 64'd0);
    check("clrdrop_ovf", 64'(o_overflow), 64'd0);
    check("clrdrop_count", 64'(o_count), 64'd8);
    check("clrdrop_samples", 64'(o_samples), 64'd0);

    // Drain and verify order
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d", k), 64'(o_data), 64'(drain_exp[k]));
      o_ready = 1'b1;
      step();
    end
    o_ready = 1'b0;
    check("drain_count", 64'(o_count), 64'd0);
    check("drain_valid", 64'(o_valid), 64'd0);
    check("drain_data", 64'(o_data), 64'd0);

    // Asynchronous reset mid-operation
    for (int v = 11; v < 15; v++) push(32'(v));
    check("pre_rst_count", 64'(o_count), 64'd4);
    #2 reset = 1'b1;
    #1 check_reset_state("async");
    #1 reset = 1'b0;
    step();
    push(32'd9);
    check("post_rst_data", 64'(o_data), 64'd9);
    check("post_rst_count", 64'(o_count), 64'd1);
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;

    // Streaming with downstream always ready
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    o_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      i_valid = 1'b1;
      i_value = 32'(n % 10);
      step();
      check($sformatf("stream%0d", n), 64'(o_data), 64'(n % 10));
    end
    i_valid = 1'b0;
    step();
    o_ready = 1'b0;
    check("stream_count", 64'(o_count), 64'd0);
    check("stream_drops", 64'(o_drops), 64'd0);
    check("stream_samples", 64'(o_samples), 64'd300);
    check("stream_sum", 64'(o_sum), 64'd1350);
    check("stream_min", 64'(o_min), 64'd0);
    check("stream_max", 64'(o_max), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
